// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-0 responder modelling an accelerometer register map
// Ports: clock, reset (synchronous, active-low); sclk/cs/mosi in, miso out (SPI pins,
//        inputs asynchronous to clock); sample_valid with x/y/z_data loads 12-bit signed
//        samples; wr_strobe/wr_addr/wr_data report each committed write; busy is high
//        whenever the FSM is not IDLE.
// Optional: define SPI_RESP_SNAPSHOT_EN to serve X/Y/Z reads from a copy taken at cs fall.
module spi_accel_responder #(
    parameter int         NUM_REGS = 64,
    parameter logic [7:0] DEVID    = 8'hAD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    input  logic        sample_valid,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t         state, state_nx;
    logic [1:0]     sclk_sy, cs_sy, mosi_sy;
    logic           sclk_d, cs_d;
    logic           sclk_rise, sclk_fall, cs_fall, cs_hi, byte_done;
    logic [2:0]     bit_cnt;
    logic [6:0]     rx;
    logic [7:0]     rx_byte, tx, rd_byte, a8;
    logic [AW-1:0]  addr;
    logic           is_read;
    logic [11:0]    x_reg, y_reg, z_reg, x_rd, y_rd, z_rd, smp;
    logic [7:0]     scratch [NUM_REGS];

    // Synchronizers and edge history run through reset so that a cs already low at
    // reset release is seen as a level, not a falling edge.
    always_ff @(posedge clock) begin
        sclk_sy <= {sclk_sy[0], sclk};
        cs_sy   <= {cs_sy[0], cs};
        mosi_sy <= {mosi_sy[0], mosi};
        sclk_d  <= sclk_sy[1];
        cs_d    <= cs_sy[1];
    end

    assign cs_hi     = cs_sy[1];
    assign sclk_rise = sclk_sy[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sy[1] & sclk_d;
    assign cs_fall   = cs_d & ~cs_hi;
    assign rx_byte   = {rx, mosi_sy[1]};
    assign byte_done = sclk_rise & ~cs_hi & (bit_cnt == 3'd7);
    assign a8        = 8'(addr);

    always_ff @(posedge clock)
        state <= !reset ? IDLE : state_nx;

    // IDLE with cs low but no falling edge only happens after reset release mid-transaction.
    always_comb begin
        state_nx = state;
        if (cs_hi)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = cs_fall ? CMD : IGNORE;
        else if (byte_done && state == CMD)
            state_nx = (rx_byte == 8'h0B || rx_byte == 8'h0A) ? ADDR : IGNORE;
        else if (byte_done && state == ADDR)
            state_nx = DATA;
    end

    always_comb begin
        busy = state != IDLE;
        miso = (state == DATA) && is_read && !cs_hi && tx[7];
    end

`ifdef SPI_RESP_SNAPSHOT_EN
    logic [11:0] x_snap, y_snap, z_snap;
    always_ff @(posedge clock)
        if (!reset) begin
            x_snap <= '0;
            y_snap <= '0;
            z_snap <= '0;
        end else if (state == IDLE && cs_fall) begin
            x_snap <= x_reg;
            y_snap <= y_reg;
            z_snap <= z_reg;
        end
    assign x_rd = x_snap;
    assign y_rd = y_snap;
    assign z_rd = z_snap;
`else
    assign x_rd = x_reg;
    assign y_rd = y_reg;
    assign z_rd = z_reg;
`endif

    // 0x0E/0x0F -> X, 0x10/0x11 -> Y, 0x12/0x13 -> Z, picked by address bits [2:1].
    assign smp = (a8[2:1] == 2'b11) ? x_rd : (a8[2:1] == 2'b00) ? y_rd : z_rd;
    assign rd_byte = (a8 == 8'h00) ? DEVID :
                     (a8 >= 8'h20) ? scratch[addr] :
                     (a8 >= 8'h0E && a8 <= 8'h13) ? (a8[0] ? {{4{smp[11]}}, smp[11:8]} : smp[7:0]) :
                     8'h00;

    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                scratch[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (sample_valid) begin
                x_reg <= x_data;
                y_reg <= y_data;
                z_reg <= z_data;
            end
            if (cs_hi)
                bit_cnt <= '0;
            else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx      <= rx_byte[6:0];
            end
            if (byte_done && state == CMD)
                is_read <= rx_byte == 8'h0B;
            if (byte_done && state == ADDR)
                addr <= rx_byte[AW-1:0];
            if (byte_done && state == DATA) begin
                addr <= addr + AW'(1);
                if (!is_read && a8 >= 8'h20) begin
                    wr_strobe     <= 1'b1;
                    wr_addr       <= a8;
                    wr_data       <= rx_byte;
                    scratch[addr] <= rx_byte;
                end
            end
            // A falling edge with bit_cnt back at 0 closes the previous byte: load the next one.
            if (sclk_fall && state == DATA && is_read)
                tx <= (bit_cnt == 3'd0) ? rd_byte : {tx[6:0], 1'b0};
        end
    end
endmodule
